cargador_instrucciones: RTL
===========================

# cargador_instrucciones

Write-side loader for the byte-wide instruction memory. It accepts 32-bit instruction words over a valid/ready handshake. Each word is written as four consecutive byte writes in big-endian order, most significant byte at the lowest address, so the fetch side reads back `{mem[A], mem[A+1], mem[A+2], mem[A+3]}` as the original word. It sits between the program source (testbench, UART receiver or boot ROM) and the write port of the instruction memory array, and it tracks fill level, completion and overflow.

## Interface
Parameters:
- `PROFUNDIDAD`, 256: memory size in bytes; must be a multiple of 4.
- `ANCHO_DIR`, 8: byte address width, log2(`PROFUNDIDAD`).
- `DIR_INICIO`, 0: first byte address of a load session; must be a multiple of 4.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `inicio`, in, 1: start or restart a load session; honoured only in INACTIVO and FIN.
- `palabra`, in, 32: instruction word.
- `palabra_valida`, in, 1: `palabra` and `ultima` are valid.
- `ultima`, in, 1: the current word is the last of the program.
- `palabra_lista`, out, 1: loader can accept a word.
- `mem_we`, out, 1: byte write enable to the instruction memory.
- `mem_dir`, out, `ANCHO_DIR`: byte write address.
- `mem_dato`, out, 8: byte write data.
- `cargando`, out, 1: session active (ESPERA or ESCRIBE).
- `fin`, out, 1: session finished, either normally or on overflow; sticky until `inicio` or `rst`.
- `desborde`, out, 1: a word was rejected for lack of space; sticky until `inicio` or `rst`.
- `palabras_cargadas`, out, `ANCHO_DIR`: number of words fully written in the current session.

## Operation
- **Internal registers:**
  - state
  - byte pointer `ptr` (`ANCHO_DIR`+1 bits)
  - byte index `idx` (2 bits)
  - captured word and captured `ultima`
  - word counter
  - `fin` and `desborde` flags
- **Output drive:** all outputs are decoded from registers only. There is no combinational path from any input to any output.
- **State machine:** INACTIVO, ESPERA, ESCRIBE, FIN.
- **INACTIVO:**
  - `palabra_lista`=0, `cargando`=0.
  - On `inicio`: `ptr`←`DIR_INICIO`, counter←0, `fin`←0, `desborde`←0, go to ESPERA.
- **ESPERA:**
  - `palabra_lista`=1, `cargando`=1.
  - A transfer occurs when `palabra_valida`=1 and `palabra_lista`=1 at an edge.
  - On transfer, capture `palabra` and `ultima`.
  - If `ptr` > `PROFUNDIDAD`−4 (no room for 4 bytes): `desborde`←1, `fin`←1, go to FIN, and perform no write.
  - Otherwise: `idx`←0, go to ESCRIBE.
- **ESCRIBE:**
  - `palabra_lista`=0, `mem_we`=1, `mem_dir`=`ptr`+`idx` (truncated to `ANCHO_DIR`).
  - `mem_dato` per `idx`: 0 → `word[31:24]`, 1 → `[23:16]`, 2 → `[15:8]`, 3 → `[7:0]`.
  - `idx` increments each cycle.
  - At `idx`=3: `ptr`←`ptr`+4 and counter←counter+1.
  - Next state at `idx`=3: FIN with `fin`←1 if the captured `ultima`=1, otherwise ESPERA.
- **FIN:** `cargando`=0, `palabra_lista`=0. `inicio` behaves exactly as in INACTIVO.
- **`inicio` outside INACTIVO/FIN:** ignored in ESPERA and ESCRIBE. A word in progress always completes all 4 bytes.
- **`palabra_valida` outside ESPERA:** ignored. The source must hold `palabra`/`ultima` stable until the transfer.
- **Idle outputs:** when not in ESCRIBE, `mem_we`=0, `mem_dir`=`ptr` (truncated) and `mem_dato`=`word[31:24]` of the captured word.
- **Memory reach:** the loader never writes at or beyond `PROFUNDIDAD`. Addresses never wrap within a session.

## Timing
- **Reset values:** state INACTIVO, `ptr`=`DIR_INICIO`, captured word=0.
  - Outputs: `palabra_lista`=0, `mem_we`=0, `mem_dir`=`DIR_INICIO`, `mem_dato`=0, `cargando`=0, `fin`=0, `desborde`=0, `palabras_cargadas`=0.
- **Start:** `inicio` sampled at edge E gives `palabra_lista`=1 from E+1.
- **Write latency:** a transfer at edge N puts the 4 byte writes in cycles N+1 to N+4. The memory samples them at edges N+1 to N+4.
  - `palabras_cargadas` increments at edge N+4.
  - `palabra_lista` returns high in the cycle after edge N+4, giving 1 word per 5 cycles sustained.
- **End of program:** a transfer with `ultima`=1 at N gives `fin`=1 and `cargando`=0 from edge N+4.
- **Overflow:** an overflowing transfer at N gives `desborde`=`fin`=1 from edge N+1, with `mem_we` never asserted.
- **`rst` priority:** `rst` mid-ESCRIBE aborts at that edge. Remaining bytes are not written and all values return to reset.
- **`rst` and `inicio` together:** when both are high at the same edge, `rst` wins.

## Test plan
- **Reset:** reset, then idle 3 cycles → all outputs at reset values, `mem_we` never 1.
- **Single word:** `inicio`; one word `32'h8C220004` with `ultima`=1 → writes (0,`8C`), (1,`22`), (2,`00`), (3,`04`) on 4 consecutive cycles; `fin`=1 and `palabras_cargadas`=1 at N+4; read-back through the instruction memory at address 0 = `8C220004`.
- **Back-to-back stream:** 3 words with `palabra_valida` held high and `ultima` on the third → transfers exactly 5 cycles apart; bytes at addresses 0–11 in order; `palabras_cargadas`=3.
- **Overflow:** `PROFUNDIDAD`=256, `DIR_INICIO`=0; 64 words with no `ultima`, then a 65th → the 65th produces no write; `desborde`=`fin`=1; `palabras_cargadas`=64; last write at address 255.
- **Reset and restart:** assert `rst` during the second byte of a word → only addresses 0 and 1 written; then `inicio` restarts at `DIR_INICIO`.
- **Ignored inputs:** `inicio` pulsed in ESCRIBE and `palabra_valida` pulsed in ESCRIBE → no effect on write sequence or counters. A new `inicio` from FIN clears `fin`/`desborde` and reloads from address 0.

Source files
------------

// File: rtl/cargador_instrucciones.sv
// cargador_instrucciones: writes 32-bit instruction words into a byte-wide memory, MSB first.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   inicio_i                 start/restart a load session (INACTIVO or FIN only)
//   palabra_i, ultima_i      instruction word and last-word flag, qualified by palabra_valida_i
//   palabra_lista_o          ready for a word
//   mem_we_o/dir_o/dato_o    byte write port of the instruction memory
//   cargando_o, fin_o        session active / session finished (sticky)
//   desborde_o               word rejected for lack of space (sticky)
//   palabras_cargadas_o      words fully written in this session
module cargador_instrucciones #(
    parameter int PROFUNDIDAD = 256,
    parameter int ANCHO_DIR   = 8,
    parameter int DIR_INICIO  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inicio_i,
    input  logic [31:0]          palabra_i,
    input  logic                 palabra_valida_i,
    input  logic                 ultima_i,
    output logic                 palabra_lista_o,
    output logic                 mem_we_o,
    output logic [ANCHO_DIR-1:0] mem_dir_o,
    output logic [7:0]           mem_dato_o,
    output logic                 cargando_o,
    output logic                 fin_o,
    output logic                 desborde_o,
    output logic [ANCHO_DIR-1:0] palabras_cargadas_o
);
    typedef enum logic [1:0] {INACTIVO, ESPERA, ESCRIBE, FIN} estado_t;
    localparam logic [ANCHO_DIR:0] PTR_INICIO = (ANCHO_DIR+1)'(DIR_INICIO);
    localparam logic [ANCHO_DIR:0] PTR_LIMITE = (ANCHO_DIR+1)'(PROFUNDIDAD-4);
    localparam logic [ANCHO_DIR:0] PTR_PASO   = (ANCHO_DIR+1)'(4);
    localparam logic [ANCHO_DIR-1:0] CNT_UNO  = ANCHO_DIR'(1);
    estado_t              estado_q;
    logic [ANCHO_DIR:0]   ptr_q;
    logic [1:0]           idx_q;
    logic [31:0]          word_q;
    logic                 ult_q;
    logic [ANCHO_DIR-1:0] cnt_q;
    logic                 fin_q;
    logic                 desb_q;
    logic                 escribe;
    logic [1:0]           sel;
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= INACTIVO;
            ptr_q    <= PTR_INICIO;
            idx_q    <= 2'd0;
            word_q   <= 32'd0;
            ult_q    <= 1'b0;
            cnt_q    <= '0;
            fin_q    <= 1'b0;
            desb_q   <= 1'b0;
        end else begin
            case (estado_q)
                INACTIVO, FIN: begin
                    if (inicio_i) begin
                        ptr_q    <= PTR_INICIO;
                        cnt_q    <= '0;
                        fin_q    <= 1'b0;
                        desb_q   <= 1'b0;
                        estado_q <= ESPERA;
                    end
                end
                ESPERA: begin
                    if (palabra_valida_i) begin
                        word_q <= palabra_i;
                        ult_q  <= ultima_i;
                        // ptr is one bit wider than the address so a full memory never wraps to 0
                        if (ptr_q > PTR_LIMITE) begin
                            desb_q   <= 1'b1;
                            fin_q    <= 1'b1;
                            estado_q <= FIN;
                        end else begin
                            idx_q    <= 2'd0;
                            estado_q <= ESCRIBE;
                        end
                    end
                end
                ESCRIBE: begin
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        ptr_q    <= ptr_q + PTR_PASO;
                        cnt_q    <= cnt_q + CNT_UNO;
                        fin_q    <= ult_q;
                        estado_q <= ult_q ? FIN : ESPERA;
                    end
                end
            endcase
        end
    end
    assign escribe             = estado_q == ESCRIBE;
    assign sel                 = escribe ? idx_q : 2'd0;
    assign palabra_lista_o     = estado_q == ESPERA;
    assign cargando_o          = estado_q == ESPERA || escribe;
    assign mem_we_o            = escribe;
    assign mem_dir_o           = ptr_q[ANCHO_DIR-1:0] + ANCHO_DIR'(sel);
    assign mem_dato_o          = sel == 2'd0 ? word_q[31:24] :
                                 sel == 2'd1 ? word_q[23:16] :
                                 sel == 2'd2 ? word_q[15:8]  : word_q[7:0];
    assign fin_o               = fin_q;
    assign desborde_o          = desb_q;
    assign palabras_cargadas_o = cnt_q;
endmodule
